// File: rtl/intcvt_unpack.sv
// rtl/intcvt_unpack.sv - int-to-FP front end: sign/abs, clz, normalize; optional skid via INTCVT_SKID_EN
module intcvt_unpack #(
  parameter int XLEN = 64,
  parameter int LZW  = $clog2(XLEN + 1)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            Flush,
  input  logic            InValid,
  output logic            InReady,
  input  logic [XLEN-1:0] Int,
  input  logic            Signed,
  input  logic            Int64,
  output logic            OutValid,
  input  logic            OutReady,
  output logic            Xs,
  output logic [XLEN-1:0] Mag,
  output logic [LZW-1:0]  Lz,
  output logic            Zero
);

  logic            s1_valid, s1_xs;
  logic [XLEN-1:0] s1_abs;
  logic            s2_valid, s2_xs, s2_zero;
  logic [XLEN-1:0] s2_mag;
  logic [LZW-1:0]  s2_lz;

  logic            accept, s1_ready, s2_ready, s1_move;
  logic            s1_valid_n, s2_valid_n;
  logic [XLEN-1:0] ext, abs_v, mag_v;
  logic            xs_v;
  logic [LZW-1:0]  lz_v;

  // Extend the selected source width and take its magnitude; -(2^(XLEN-1)) wraps to itself, which is the correct unsigned magnitude
  always_comb begin
    ext       = {XLEN{Signed & Int[31]}};
    ext[31:0] = Int[31:0];
    xs_v      = Signed & Int[31];
    if (Int64) begin
      ext  = Int;
      xs_v = Signed & Int[XLEN-1];
    end
    abs_v = xs_v ? -ext : ext;
  end

  // Count leading zeros of the S1 magnitude (highest set bit wins) and left-normalize it
  always_comb begin
    lz_v = LZW'(XLEN);
    for (int i = 0; i < XLEN; i++) begin
      if (s1_abs[i]) lz_v = LZW'(XLEN - 1 - i);
    end
    mag_v = s1_abs << lz_v;
  end

  assign s1_ready = !s1_valid | s2_ready;
  assign s1_move  = s1_valid & s2_ready;
  assign accept   = InValid & InReady;

  // Next-cycle occupancy of the two compute stages; Flush wins over any accept
  always_comb begin
    s1_valid_n = !Flush & (accept | (s1_valid & !s2_ready));
    s2_valid_n = !Flush & (s1_move | (s2_valid & !s2_ready));
  end

  // S1: capture sign and magnitude on accept
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_xs    <= 1'b0;
      s1_abs   <= '0;
    end else begin
      s1_valid <= s1_valid_n;
      if (accept) begin
        s1_xs  <= xs_v;
        s1_abs <= abs_v;
      end
    end
  end

  // S2: capture normalized magnitude; a zero value never carries a sign
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s2_valid <= 1'b0;
      s2_xs    <= 1'b0;
      s2_zero  <= 1'b0;
      s2_mag   <= '0;
      s2_lz    <= '0;
    end else begin
      s2_valid <= s2_valid_n;
      if (s1_move) begin
        s2_xs   <= s1_xs & (s1_abs != '0);
        s2_zero <= (s1_abs == '0);
        s2_mag  <= mag_v;
        s2_lz   <= lz_v;
      end
    end
  end

`ifdef INTCVT_SKID_EN
  logic            sk_valid, sk_xs, sk_zero, sk_load, sk_valid_n, in_ready_q;
  logic [XLEN-1:0] sk_mag;
  logic [LZW-1:0]  sk_lz;

  // S2 may advance whenever the skid slot is free or is being drained this cycle
  assign s2_ready = !s2_valid | !sk_valid | OutReady;
  // S2 parks in the skid slot unless it is going straight out
  assign sk_load  = s2_valid & s2_ready & (sk_valid | !OutReady);

  // Next-cycle skid occupancy
  always_comb begin
    sk_valid_n = !Flush & (sk_load | (sk_valid & !OutReady));
  end

  // Skid slot, plus a registered InReady that is low only when all three slots will be full
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sk_valid   <= 1'b0;
      sk_xs      <= 1'b0;
      sk_zero    <= 1'b0;
      sk_mag     <= '0;
      sk_lz      <= '0;
      in_ready_q <= 1'b1;
    end else begin
      sk_valid   <= sk_valid_n;
      in_ready_q <= !(s1_valid_n & s2_valid_n & sk_valid_n);
      if (sk_load) begin
        sk_xs   <= s2_xs;
        sk_zero <= s2_zero;
        sk_mag  <= s2_mag;
        sk_lz   <= s2_lz;
      end
    end
  end

  assign InReady  = in_ready_q;
  assign OutValid = sk_valid | s2_valid;
  assign Xs       = sk_valid ? sk_xs   : s2_xs;
  assign Zero     = sk_valid ? sk_zero : s2_zero;
  assign Mag      = sk_valid ? sk_mag  : s2_mag;
  assign Lz       = sk_valid ? sk_lz   : s2_lz;
`else
  assign s2_ready = !s2_valid | OutReady;
  assign InReady  = s1_ready;
  assign OutValid = s2_valid;
  assign Xs       = s2_xs;
  assign Zero     = s2_zero;
  assign Mag      = s2_mag;
  assign Lz       = s2_lz;
`endif

  // 64-bit sources only exist when the datapath is 64 bits wide
  always_ff @(posedge clk) begin
    if (!reset && InValid) assert (!(Int64 && XLEN == 32));
  end

endmodule

// File: tb/tb_intcvt_unpack.sv
// tb/tb_intcvt_unpack.sv - scoreboard bench for intcvt_unpack
module tb_intcvt_unpack;

`ifdef INTCVT_SKID_EN
  localparam int CAP = 3;
`else
  localparam int CAP = 2;
`endif

  logic        clk, reset, Flush, InValid, InReady, Signed, Int64, OutValid, OutReady, Xs, Zero;
  logic [63:0] Int, Mag;
  logic [6:0]  Lz;

  typedef struct packed {
    logic        xs;
    logic [63:0] mag;
    logic [6:0]  lz;
    logic        zero;
  } exp_t;

  exp_t        sb[$];
  exp_t        pend;
  int          n_cmp = 0;
  int          n_bad = 0;
  logic        rnd_rdy = 1'b0;
  logic        s_inready, s_outvalid;
  logic [63:0] s_mag;

  intcvt_unpack #(.XLEN(64)) dut (
    .clk(clk), .reset(reset), .Flush(Flush), .InValid(InValid), .InReady(InReady),
    .Int(Int), .Signed(Signed), .Int64(Int64), .OutValid(OutValid), .OutReady(OutReady),
    .Xs(Xs), .Mag(Mag), .Lz(Lz), .Zero(Zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=summary");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic exp_t mk(input logic xs, input logic [63:0] mag, input logic [6:0] lz, input logic zero);
    exp_t e;
    e.xs = xs; e.mag = mag; e.lz = lz; e.zero = zero;
    return e;
  endfunction

  function automatic exp_t model(input logic [63:0] v, input logic s, input logic i64);
    exp_t        e;
    logic [63:0] a;
    logic        neg;
    if (i64) begin
      neg = s & v[63];
      a   = neg ? (64'd0 - v) : v;
    end else begin
      neg = s & v[31];
      a   = neg ? (64'h1_0000_0000 - {32'd0, v[31:0]}) : {32'd0, v[31:0]};
    end
    e.xs   = neg;
    e.zero = (a == 64'd0);
    e.mag  = a;
    e.lz   = 7'd0;
    if (a == 64'd0) e.lz = 7'd64;
    else while (!e.mag[63]) begin
      e.mag = e.mag << 1;
      e.lz  = e.lz + 7'd1;
    end
    return e;
  endfunction

  task automatic step(output bit acc);
    exp_t e;
    @(negedge clk);
    s_inready  = InReady;
    s_outvalid = OutValid;
    s_mag      = Mag;
    acc = InValid && InReady && !reset;
    if (acc && !Flush) sb.push_back(pend);
    if (OutValid && OutReady && !reset) begin
      if (sb.size() == 0) chk("out_without_expect", OutValid, 1'b0);
      else begin
        e = sb.pop_front();
        chk("xs", Xs, e.xs);
        chk("mag", Mag, e.mag);
        chk("lz", Lz, e.lz);
        chk("zero", Zero, e.zero);
      end
    end
    @(posedge clk);
    #1;
    if (rnd_rdy) OutReady = ($urandom_range(0, 3) != 0);
  endtask

  task automatic issue(input logic [63:0] v, input logic s, input logic i64, input exp_t e, output int n);
    bit acc;
    Int = v; Signed = s; Int64 = i64; pend = e; InValid = 1'b1;
    n = 0; acc = 1'b0;
    while (!acc && n < 30) begin
      step(acc);
      n++;
    end
    chk("issue_accepted", acc, 1'b1);
    InValid = 1'b0;
  endtask

  task automatic drain();
    int k;
    bit acc;
    k = 0;
    rnd_rdy = 1'b0; OutReady = 1'b1; InValid = 1'b0;
    while (sb.size() != 0 && k < 30) begin
      step(acc);
      k++;
    end
    chk("drain_empty", sb.size(), 0);
    chk("drain_outvalid", OutValid, 1'b0);
  endtask

  initial begin
    int          n;
    bit          acc;
    logic [63:0] v;
    logic        s, i64;
    logic [63:0] t5v [4];
    logic [63:0] e0mag;

    reset = 1'b1; Flush = 1'b0; InValid = 1'b0; Int = '0; Signed = 1'b0; Int64 = 1'b0; OutReady = 1'b1;
    #12;
    chk("rst_outvalid", OutValid, 1'b0);
    chk("rst_inready", InReady, 1'b1);
    chk("rst_xs", Xs, 1'b0);
    chk("rst_mag", Mag, 64'd0);
    chk("rst_lz", Lz, 7'd0);
    chk("rst_zero", Zero, 1'b0);
    @(negedge clk); #2 reset = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_inready", InReady, 1'b1);

    // T1 with latency check: accept, S1 after one edge, OutValid after two
    issue(64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, mk(1'b1, 64'h8000_0000_0000_0000, 7'd63, 1'b0), n);
    chk("t1_steps", n, 1);
    chk("lat_after_1", OutValid, 1'b0);
    step(acc);
    chk("lat_after_2", OutValid, 1'b1);
    drain();

    // Directed vectors back-to-back at full throughput
    issue(64'hFFFF_FFFF_8000_0000, 1'b0, 1'b0, mk(1'b0, 64'h8000_0000_0000_0000, 7'd32, 1'b0), n);
    chk("tp_t2", n, 1);
    issue(64'h0000_0000_8000_0000, 1'b1, 1'b0, mk(1'b1, 64'h8000_0000_0000_0000, 7'd32, 1'b0), n);
    chk("tp_t3", n, 1);
    issue(64'd0, 1'b1, 1'b1, mk(1'b0, 64'd0, 7'd64, 1'b1), n);
    chk("tp_t4a", n, 1);
    issue(64'd0, 1'b0, 1'b0, mk(1'b0, 64'd0, 7'd64, 1'b1), n);
    issue(64'hFFFF_FFFF_0000_0000, 1'b1, 1'b0, mk(1'b0, 64'd0, 7'd64, 1'b1), n);
    issue(64'h8000_0000_0000_0000, 1'b1, 1'b1, mk(1'b1, 64'h8000_0000_0000_0000, 7'd0, 1'b0), n);
    issue(64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b1, mk(1'b0, 64'hFFFF_FFFF_FFFF_FFFE, 7'd1, 1'b0), n);
    issue(64'h1234_5678_FFFF_FFFF, 1'b1, 1'b0, mk(1'b1, 64'h8000_0000_0000_0000, 7'd63, 1'b0), n);
    issue(64'h8000_0000_0000_0000, 1'b0, 1'b1, mk(1'b0, 64'h8000_0000_0000_0000, 7'd0, 1'b0), n);
    chk("tp_last", n, 1);
    drain();

    // Random operands with random downstream backpressure
    rnd_rdy = 1'b1;
    for (int i = 0; i < 40; i++) begin
      v   = {$urandom, $urandom};
      if (i % 4 == 0) v = 64'($urandom_range(0, 5));
      if (i % 4 == 1) v = v >> $urandom_range(0, 63);
      s   = 1'($urandom_range(0, 1));
      i64 = 1'($urandom_range(0, 1));
      issue(v, s, i64, model(v, s, i64), n);
    end
    drain();

    // T5: stall fills the pipe, InReady drops, output held stable, order kept
    t5v = '{64'd1, 64'h30, 64'hFFFF_FFFF_FFFF_FFFB, 64'h1_2345_6789};
    e0mag = model(t5v[0], 1'b1, 1'b1).mag;
    OutReady = 1'b0;
    for (int i = 0; i < CAP; i++) begin
      issue(t5v[i], 1'b1, 1'b1, model(t5v[i], 1'b1, 1'b1), n);
      chk("t5_fill_steps", n, 1);
    end
    Int = t5v[CAP]; Signed = 1'b1; Int64 = 1'b1; pend = model(t5v[CAP], 1'b1, 1'b1); InValid = 1'b1;
    for (int c = 0; c < 4; c++) begin
      step(acc);
      chk("t5_inready_low", s_inready, 1'b0);
      chk("t5_outvalid", s_outvalid, 1'b1);
      chk("t5_mag_stable", s_mag, e0mag);
    end
    OutReady = 1'b1;
    for (int i = CAP; i < 4; i++) issue(t5v[i], 1'b1, 1'b1, model(t5v[i], 1'b1, 1'b1), n);
    drain();

    // T6a: Flush with two in flight; the same-cycle accept is discarded
    OutReady = 1'b0;
    issue(64'd7, 1'b0, 1'b1, model(64'd7, 1'b0, 1'b1), n);
    issue(64'd9, 1'b0, 1'b1, model(64'd9, 1'b0, 1'b1), n);
    Int = 64'd11; pend = model(64'd11, 1'b0, 1'b1); InValid = 1'b1; Flush = 1'b1;
    step(acc);
    Flush = 1'b0; InValid = 1'b0;
    sb.delete();
    chk("flush_outvalid", OutValid, 1'b0);
    chk("flush_inready", InReady, 1'b1);
    OutReady = 1'b1;
    issue(64'd13, 1'b1, 1'b0, model(64'd13, 1'b1, 1'b0), n);
    drain();

    // T6b: reset mid-stall drops everything at once
    OutReady = 1'b0;
    issue(64'd21, 1'b0, 1'b0, model(64'd21, 1'b0, 1'b0), n);
    issue(64'd22, 1'b0, 1'b0, model(64'd22, 1'b0, 1'b0), n);
    step(acc);
    step(acc);
    #2 reset = 1'b1;
    #1;
    chk("midrst_outvalid", OutValid, 1'b0);
    chk("midrst_mag", Mag, 64'd0);
    chk("midrst_inready", InReady, 1'b1);
    sb.delete();
    @(negedge clk); #2 reset = 1'b0;
    @(posedge clk); #1;
    chk("rel_inready", InReady, 1'b1);
    chk("rel_outvalid", OutValid, 1'b0);
    OutReady = 1'b1;
    issue(64'hFFFF_FFFF_FFFF_FFF0, 1'b1, 1'b1, model(64'hFFFF_FFFF_FFFF_FFF0, 1'b1, 1'b1), n);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
